gbus_wr_arbiter: RTL and testbench

Per-head arbiter that merges the `out_gbus_*` write streams of all `HEAD_CORE_NUM` cores in a head onto the single shared head global bus. Each core drives its bus writes unconditionally, with no backpressure. The arbiter therefore buffers each core's writes in a small per-core FIFO and drains them round-robin, one beat per cycle, through a registered output that honours a downstream stall. Overflow is detected, sticky, and reported with the offending core ID.

---
 rtl/gbus_wr_arbiter_pkg.sv | 18 +
 rtl/gbus_req_fifo.sv | 45 ++++
 rtl/gbus_wr_arbiter.sv | 131 +++++++++++++
 tb/tb_gbus_wr_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gbus_wr_arbiter_pkg.sv
// Shared types and bus-field widths for the head global-bus write arbiter.
// The optional statistics counters are enabled with GBUS_ARB_STATS_EN.
package gbus_wr_arbiter_pkg;

  localparam int BUS_CMEM_ADDR_WIDTH  = 13;
  localparam int BUS_CORE_ADDR_WIDTH  = 4;
  localparam int HEAD_SRAM_BIAS_WIDTH = 2;
  localparam int GBUS_ADDR_W = HEAD_SRAM_BIAS_WIDTH + BUS_CORE_ADDR_WIDTH + BUS_CMEM_ADDR_WIDTH;
  localparam int GBUS_DATA_W = 32;
  localparam int GBUS_HEAD_CORE_NUM = 16;
  localparam int CORE_ID_W = $clog2(GBUS_HEAD_CORE_NUM);

  typedef struct packed {
    logic [GBUS_ADDR_W-1:0] addr;
    logic [GBUS_DATA_W-1:0] data;
  } gbus_req_t;

endpackage

// File: rtl/gbus_req_fifo.sv
// Per-core synchronous FIFO of bus write requests; a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module gbus_req_fifo
  import gbus_wr_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  gbus_req_t din,
  input  logic      pop,
  output gbus_req_t dout,
  output logic      empty,
  output logic      full
);

  localparam int PW = $clog2(DEPTH);

  gbus_req_t   mem [DEPTH];
  logic [PW:0] wptr, rptr;
  logic        do_push, do_pop;

  // Extra MSB distinguishes full from empty when the index bits match.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (PW+1)'(1);
      if (do_pop)  rptr <= rptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/gbus_wr_arbiter.sv
// Merges per-core global-bus write streams onto one stallable bus, round-robin.
// Define GBUS_ARB_STATS_EN to add completed-beat and stall-cycle counters.
module gbus_wr_arbiter
  import gbus_wr_arbiter_pkg::*;
#(
  parameter int HEAD_CORE_NUM   = GBUS_HEAD_CORE_NUM,
  parameter int CORE_NUM        = HEAD_CORE_NUM,
  parameter int GBUS_ADDR_WIDTH = GBUS_ADDR_W,
  parameter int GBUS_DATA_WIDTH = GBUS_DATA_W,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [CORE_NUM-1:0]                 in_gbus_wen,
  input  logic [CORE_NUM*GBUS_ADDR_WIDTH-1:0] in_gbus_addr,
  input  logic [CORE_NUM*GBUS_DATA_WIDTH-1:0] in_gbus_wdata,
  input  logic                                gbus_stall,
  output logic                                out_gbus_wen,
  output logic [GBUS_ADDR_WIDTH-1:0]          out_gbus_addr,
  output logic [GBUS_DATA_WIDTH-1:0]          out_gbus_wdata,
  output logic                                busy,
  input  logic                                err_clear,
  output logic                                overflow,
  output logic [$clog2(CORE_NUM)-1:0]         overflow_core_id
`ifdef GBUS_ARB_STATS_EN
  ,
  output logic [31:0]                         stat_beats,
  output logic [31:0]                         stat_stall_cycles
`endif
);

  localparam int ID_W = $clog2(CORE_NUM);

  gbus_req_t [CORE_NUM-1:0] fifo_dout;
  logic [CORE_NUM-1:0]      fifo_empty, fifo_full, fifo_pop, ovf_vec;
  logic [ID_W-1:0]          rr_ptr, gnt_id, ovf_first;
  logic                     gnt_vld, can_load;

  // Output register may take a new beat when empty or completing this cycle.
  assign can_load = !out_gbus_wen || !gbus_stall;

  genvar i;
  generate
    for (i = 0; i < CORE_NUM; i++) begin : g_core
      gbus_req_t din;
      assign din = {in_gbus_addr[i*GBUS_ADDR_WIDTH +: GBUS_ADDR_WIDTH],
                    in_gbus_wdata[i*GBUS_DATA_WIDTH +: GBUS_DATA_WIDTH]};
      assign fifo_pop[i] = gnt_vld && can_load && (gnt_id == ID_W'(i));
      assign ovf_vec[i]  = in_gbus_wen[i] && fifo_full[i] && !fifo_pop[i];

      gbus_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_gbus_wen[i]),
        .din   (din),
        .pop   (fifo_pop[i]),
        .dout  (fifo_dout[i]),
        .empty (fifo_empty[i]),
        .full  (fifo_full[i])
      );
    end
  endgenerate

  // First non-empty FIFO at or after rr_ptr, wrapping.
  always_comb begin
    logic [ID_W:0] s;
    s       = '0;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int k = 0; k < CORE_NUM; k++) begin
      s = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (s >= (ID_W+1)'(CORE_NUM)) s = s - (ID_W+1)'(CORE_NUM);
      if (!gnt_vld && !fifo_empty[s[ID_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_id  = s[ID_W-1:0];
      end
    end
  end

  always_comb begin
    ovf_first = '0;
    for (int k = CORE_NUM-1; k >= 0; k--)
      if (ovf_vec[k]) ovf_first = ID_W'(k);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_gbus_wen   <= 1'b0;
      out_gbus_addr  <= '0;
      out_gbus_wdata <= '0;
      rr_ptr         <= '0;
      busy           <= 1'b0;
    end else begin
      busy <= !(&fifo_empty) || out_gbus_wen;
      if (can_load) begin
        out_gbus_wen   <= gnt_vld;
        out_gbus_addr  <= gnt_vld ? fifo_dout[gnt_id].addr : '0;
        out_gbus_wdata <= gnt_vld ? fifo_dout[gnt_id].data : '0;
        if (gnt_vld)
          rr_ptr <= (gnt_id == ID_W'(CORE_NUM-1)) ? '0 : gnt_id + ID_W'(1);
      end
    end
  end

  // A new overflow beats a simultaneous clear and reloads the ID.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow         <= 1'b0;
      overflow_core_id <= '0;
    end else if ((|ovf_vec) && (!overflow || err_clear)) begin
      overflow         <= 1'b1;
      overflow_core_id <= ovf_first;
    end else if (err_clear) begin
      overflow         <= 1'b0;
      overflow_core_id <= '0;
    end
  end

`ifdef GBUS_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || err_clear) begin
      stat_beats        <= '0;
      stat_stall_cycles <= '0;
    end else if (out_gbus_wen) begin
      if (!gbus_stall && stat_beats != '1)       stat_beats        <= stat_beats + 32'd1;
      if (gbus_stall && stat_stall_cycles != '1) stat_stall_cycles <= stat_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gbus_wr_arbiter.sv
// Bench for gbus_wr_arbiter: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_gbus_wr_arbiter;

  localparam int N  = 16;
  localparam int AW = 19;
  localparam int DW = 32;
  localparam int D  = 4;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    in_gbus_wen;
  logic [N*AW-1:0] in_gbus_addr;
  logic [N*DW-1:0] in_gbus_wdata;
  logic            gbus_stall, err_clear;
  logic            out_gbus_wen, busy, overflow;
  logic [AW-1:0]   out_gbus_addr;
  logic [DW-1:0]   out_gbus_wdata;
  logic [3:0]      overflow_core_id;
`ifdef GBUS_ARB_STATS_EN
  logic [31:0]     stat_beats, stat_stall_cycles;
`endif

  gbus_wr_arbiter #(
    .HEAD_CORE_NUM(N), .CORE_NUM(N), .GBUS_ADDR_WIDTH(AW),
    .GBUS_DATA_WIDTH(DW), .FIFO_DEPTH(D)
  ) dut (
    .clk(clk), .rst(rst), .in_gbus_wen(in_gbus_wen), .in_gbus_addr(in_gbus_addr),
    .in_gbus_wdata(in_gbus_wdata), .gbus_stall(gbus_stall),
    .out_gbus_wen(out_gbus_wen), .out_gbus_addr(out_gbus_addr),
    .out_gbus_wdata(out_gbus_wdata), .busy(busy), .err_clear(err_clear),
    .overflow(overflow), .overflow_core_id(overflow_core_id)
`ifdef GBUS_ARB_STATS_EN
    , .stat_beats(stat_beats), .stat_stall_cycles(stat_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_core(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    in_gbus_addr[i*AW +: AW]  = a;
    in_gbus_wdata[i*DW +: DW] = d;
  endtask

  // Reference model: one queue per core, a round-robin start index, one output slot.
  beat_t         q [N][$];
  logic          m_wen = 1'b0, m_busy = 1'b0, m_ovf = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  int            m_rr = 0, m_id = 0;
  longint        m_beats = 0, m_stalls = 0;

  always @(posedge clk) begin : model
    bit    can_ld, any_ne;
    int    g, first;
    beat_t b;
    if (rst) begin
      for (int i = 0; i < N; i++) q[i].delete();
      m_wen = 0; m_addr = '0; m_data = '0; m_rr = 0; m_busy = 0;
      m_ovf = 0; m_id = 0; m_beats = 0; m_stalls = 0;
    end else begin
      any_ne = 0;
      for (int i = 0; i < N; i++) if (q[i].size() > 0) any_ne = 1;
      if (err_clear) begin
        m_beats = 0; m_stalls = 0;
      end else if (m_wen) begin
        if (!gbus_stall && m_beats < 64'hFFFF_FFFF) m_beats++;
        if (gbus_stall && m_stalls < 64'hFFFF_FFFF) m_stalls++;
      end
      can_ld = !m_wen || !gbus_stall;
      g = -1;
      if (can_ld)
        for (int k = 0; k < N; k++)
          if (g < 0 && q[(m_rr + k) % N].size() > 0) g = (m_rr + k) % N;
      m_busy = any_ne || m_wen;
      if (can_ld) begin
        if (g >= 0) begin
          b = q[g].pop_front();
          m_wen = 1; m_addr = b.a; m_data = b.d; m_rr = (g + 1) % N;
        end else begin
          m_wen = 0; m_addr = '0; m_data = '0;
        end
      end
      first = -1;
      for (int i = 0; i < N; i++)
        if (in_gbus_wen[i]) begin
          if (q[i].size() < D) q[i].push_back({in_gbus_addr[i*AW +: AW], in_gbus_wdata[i*DW +: DW]});
          else if (first < 0) first = i;
        end
      if (first >= 0 && (!m_ovf || err_clear)) begin
        m_ovf = 1; m_id = first;
      end else if (err_clear) begin
        m_ovf = 0; m_id = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_wen", out_gbus_wen, m_wen);
      chk("m_addr", out_gbus_addr, m_addr);
      chk("m_data", out_gbus_wdata, m_data);
      chk("m_busy", busy, m_busy);
      chk("m_ovf", overflow, m_ovf);
      chk("m_ovf_id", overflow_core_id, m_id);
`ifdef GBUS_ARB_STATS_EN
      chk("m_stat_beats", stat_beats, m_beats);
      chk("m_stat_stalls", stat_stall_cycles, m_stalls);
`endif
    end
  end

  initial begin
    int k, dens;
    rst = 1; in_gbus_wen = '0; in_gbus_addr = '0; in_gbus_wdata = '0;
    gbus_stall = 0; err_clear = 0;
    repeat (3) @(negedge clk);
    chk_en = 1;
    chk("rst_wen", out_gbus_wen, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    rst = 0;
    @(negedge clk);
    chk("post_rst_wen", out_gbus_wen, 0);

    // Single write from core 3: visible two cycles later, idle by cycle 4.
    set_core(3, 19'h01234, 32'hA5A5_A5A5);
    in_gbus_wen = 16'h0008;
    @(negedge clk); in_gbus_wen = '0;
    @(negedge clk);
    chk("single_wen", out_gbus_wen, 1);
    chk("single_addr", out_gbus_addr, 19'h01234);
    chk("single_data", out_gbus_wdata, 32'hA5A5_A5A5);
    repeat (2) @(negedge clk);
    chk("single_busy_c4", busy, 0);

    // All cores at once, twice; drain order 0..15 both times.
    rst = 1; @(negedge clk); rst = 0;
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < N; i++) set_core(i, {2'b00, 4'(i), 13'(i * 7)}, $urandom);
      in_gbus_wen = '1;
      @(negedge clk); in_gbus_wen = '0;
      k = 0;
      repeat (24) begin
        @(negedge clk);
        if (out_gbus_wen) begin
          chk("burst_order", out_gbus_addr[16:13], k);
          k++;
        end
      end
      chk("burst_cnt", k, 16);
    end

    // Stall for three cycles with beats pending from cores 1, 2, 4.
    gbus_stall = 1;
    for (int i = 0; i < N; i++) set_core(i, {2'b01, 4'(i), 13'h100 + 13'(i)}, 32'h5000_0000 + i);
    in_gbus_wen = 16'h0016;
    @(negedge clk); in_gbus_wen = '0;
    @(negedge clk);
    chk("stall_wen", out_gbus_wen, 1);
    repeat (3) begin
      @(negedge clk);
      chk("stall_hold_wen", out_gbus_wen, 1);
      chk("stall_hold_addr", out_gbus_addr, {2'b01, 4'd1, 13'h101});
      chk("stall_hold_data", out_gbus_wdata, 32'h5000_0001);
    end
`ifdef GBUS_ARB_STATS_EN
    chk("stall_cycles", stat_stall_cycles, 3);
`endif
    gbus_stall = 0;
    k = 0;
    repeat (8) begin
      if (out_gbus_wen) begin
        chk("stall_seq", out_gbus_addr[16:13], (k == 0) ? 1 : (k == 1) ? 2 : 4);
        k++;
      end
      @(negedge clk);
    end
    chk("stall_cnt", k, 3);

    // Overflow: output held by a core-0 beat while core 5 pushes five beats.
    gbus_stall = 1;
    set_core(0, 19'h0, 32'h1111_1111);
    in_gbus_wen = 16'h0001;
    @(negedge clk); in_gbus_wen = '0;
    @(negedge clk);
    for (int b = 0; b < 5; b++) begin
      set_core(5, {2'b10, 4'd5, 13'(b)}, 32'hC0DE_0000 + b);
      in_gbus_wen = 16'h0020;
      @(negedge clk);
    end
    in_gbus_wen = '0;
    chk("ovf_flag", overflow, 1);
    chk("ovf_id", overflow_core_id, 5);
    gbus_stall = 0;
    k = 0;
    repeat (10) begin
      if (out_gbus_wen && out_gbus_addr[16:13] == 4'd5) begin
        chk("ovf_data", out_gbus_wdata, 32'hC0DE_0000 + k);
        k++;
      end
      @(negedge clk);
    end
    chk("ovf_cnt", k, 4);
    err_clear = 1; @(negedge clk); err_clear = 0;
    chk("ovf_clr", overflow, 0);
    chk("ovf_clr_id", overflow_core_id, 0);

    // Core 2 full FIFO granted in the same cycle it pushes.
    gbus_stall = 1;
    for (int b = 0; b < 5; b++) begin
      set_core(2, {2'b11, 4'd2, 13'(b)}, 32'hF00D_0000 + b);
      in_gbus_wen = 16'h0004;
      @(negedge clk);
    end
    set_core(2, {2'b11, 4'd2, 13'd5}, 32'hF00D_0005);
    gbus_stall = 0;
    k = 0;
    if (out_gbus_wen) begin
      chk("fullpp_data", out_gbus_wdata, 32'hF00D_0000 + k);
      k++;
    end
    @(negedge clk); in_gbus_wen = '0;
    repeat (10) begin
      if (out_gbus_wen) begin
        chk("fullpp_data", out_gbus_wdata, 32'hF00D_0000 + k);
        k++;
      end
      @(negedge clk);
    end
    chk("fullpp_cnt", k, 6);
    chk("fullpp_no_ovf", overflow, 0);

    // Reset in the middle of a burst.
    for (int i = 0; i < N; i++) set_core(i, $urandom, $urandom);
    in_gbus_wen = '1;
    @(negedge clk); in_gbus_wen = '0;
    repeat (3) @(negedge clk);
    rst = 1; @(negedge clk);
    chk("midrst_wen", out_gbus_wen, 0);
    chk("midrst_addr", out_gbus_addr, 0);
    chk("midrst_data", out_gbus_wdata, 0);
    chk("midrst_busy", busy, 0);
    rst = 0;
    k = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_gbus_wen) k++;
    end
    chk("midrst_stale", k, 0);

    // Randomized traffic with varying load, stalls, clears and resets.
    dens = 4;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) dens = $urandom_range(1, 12);
      for (int i = 0; i < N; i++) begin
        in_gbus_wen[i] = ($urandom % 64) < dens;
        set_core(i, $urandom, $urandom);
      end
      gbus_stall = ($urandom % 4) == 0;
      err_clear  = ($urandom % 50) == 0;
      rst        = ($urandom % 500) == 0;
      @(negedge clk);
    end
    in_gbus_wen = '0; gbus_stall = 0; err_clear = 0; rst = 0;
    repeat (80) @(negedge clk);
    chk("final_idle_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
